// File: rtl/run_end_detector.sv
// run_end_detector: Mealy detector that pulses y_o when a run of POL-valued
// samples ends, reporting the run length (len_o) and saturation (ovf_o).
// Optional macro RUN_DET_REG_OUT_EN registers y_o/len_o/ovf_o (one-cycle delay).
module run_end_detector #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MIN_RUN = 1,
    parameter int unsigned MAX_RUN = 0,
    parameter logic        POL     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             x_i,
    output logic             y_o,
    output logic [CNT_W-1:0] len_o,
    output logic             ovf_o
);

    localparam int unsigned SAT_I = (32'd1 << CNT_W) - 32'd1;
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_RUN);

    // Reject illegal parameter combinations at elaboration
    if (CNT_W < 1 || CNT_W > 31) begin : g_chk_w
        $error("run_end_detector: CNT_W must be in 1..31");
    end
    if (MIN_RUN < 1 || MIN_RUN > SAT_I) begin : g_chk_min
        $error("run_end_detector: MIN_RUN must be in 1..2**CNT_W-1");
    end
    if (MAX_RUN != 0 && (MAX_RUN < MIN_RUN || MAX_RUN > SAT_I)) begin : g_chk_max
        $error("run_end_detector: MAX_RUN must be 0 or in MIN_RUN..2**CNT_W-1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SAT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit;
    logic             run_end;
    logic             y_c;
    logic [CNT_W-1:0] len_c;
    logic             ovf_c;

    // State and run-length counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and run-end qualification
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CNT_ONE;
        hit     = (x_i == POL);
        run_end = 1'b0;
        y_c     = 1'b0;
        len_c   = '0;
        ovf_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_i && hit) begin
                    cnt_d   = CNT_ONE;
                    // With a 1-bit counter the first sample already saturates
                    state_d = (CNT_ONE == CNT_SAT) ? S_SAT : S_RUN;
                end
            end
            S_RUN: begin
                if (en_i) begin
                    if (hit) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_SAT) begin
                            state_d = S_SAT;
                        end
                    end else begin
                        run_end = 1'b1;
                    end
                end
            end
            S_SAT: begin
                if (en_i && !hit) begin
                    run_end = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (run_end) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            y_c     = (cnt_q >= MIN_V) &&
                      ((MAX_RUN == 0) || ((state_q != S_SAT) && (cnt_q <= MAX_V)));
            len_c   = y_c ? cnt_q : '0;
            ovf_c   = y_c && (state_q == S_SAT);
        end
    end

`ifdef RUN_DET_REG_OUT_EN
    logic             y_q;
    logic [CNT_W-1:0] len_q;
    logic             ovf_q;

    // Registered run-end report, one cycle after the terminating sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= 1'b0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            y_q   <= y_c;
            len_q <= len_c;
            ovf_q <= ovf_c;
        end
    end

    assign y_o   = y_q;
    assign len_o = len_q;
    assign ovf_o = ovf_q;
`else
    assign y_o   = y_c;
    assign len_o = len_c;
    assign ovf_o = ovf_c;
`endif

endmodule

// File: tb/tb_run_end_detector.sv
// Bench for run_end_detector: seven differently parameterised instances see
// the same stimulus; a run-length model predicts every output each cycle.
module tb_run_end_detector;

    localparam int NI = 7;
    // Per-instance parameters: CNT_W, MIN_RUN, MAX_RUN, POL
    localparam int CW   [NI] = '{8, 8, 8, 3, 8, 1, 3};
    localparam int MINR [NI] = '{1, 3, 1, 1, 1, 1, 1};
    localparam int MAXR [NI] = '{0, 0, 4, 0, 0, 0, 7};
    localparam int POLA [NI] = '{1, 1, 1, 1, 0, 1, 1};

`ifdef RUN_DET_REG_OUT_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    typedef struct packed {
        logic       y;
        logic       ovf;
        logic [7:0] len;
    } obs_t;

    logic clk;
    logic rst_n;
    logic en;
    logic x;

    logic       y_a   [NI];
    logic       ovf_a [NI];
    logic [7:0] len_a [NI];
    logic [2:0] len3;
    logic [0:0] len5;
    logic [2:0] len6;

    int n_cmp = 0;
    int n_bad = 0;

    int   run  [NI];
    obs_t prev [NI];
    int   pcnt [NI];
    int   base [NI];
    int   last_len [NI];
    int   last_ovf [NI];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    run_end_detector u0 (.clk(clk), .rst_n(rst_n), .en_i(en), .x_i(x),
                         .y_o(y_a[0]), .len_o(len_a[0]), .ovf_o(ovf_a[0]));
    run_end_detector #(.MIN_RUN(3)) u1 (.clk(clk), .rst_n(rst_n), .en_i(en), .x_i(x),
                         .y_o(y_a[1]), .len_o(len_a[1]), .ovf_o(ovf_a[1]));
    run_end_detector #(.MAX_RUN(4)) u2 (.clk(clk), .rst_n(rst_n), .en_i(en), .x_i(x),
                         .y_o(y_a[2]), .len_o(len_a[2]), .ovf_o(ovf_a[2]));
    run_end_detector #(.CNT_W(3)) u3 (.clk(clk), .rst_n(rst_n), .en_i(en), .x_i(x),
                         .y_o(y_a[3]), .len_o(len3), .ovf_o(ovf_a[3]));
    run_end_detector #(.POL(1'b0)) u4 (.clk(clk), .rst_n(rst_n), .en_i(en), .x_i(x),
                         .y_o(y_a[4]), .len_o(len_a[4]), .ovf_o(ovf_a[4]));
    run_end_detector #(.CNT_W(1)) u5 (.clk(clk), .rst_n(rst_n), .en_i(en), .x_i(x),
                         .y_o(y_a[5]), .len_o(len5), .ovf_o(ovf_a[5]));
    run_end_detector #(.CNT_W(3), .MAX_RUN(7)) u6 (.clk(clk), .rst_n(rst_n), .en_i(en), .x_i(x),
                         .y_o(y_a[6]), .len_o(len6), .ovf_o(ovf_a[6]));

    assign len_a[3] = 8'(len3);
    assign len_a[5] = 8'(len5);
    assign len_a[6] = 8'(len6);

    // What a run of 'r' samples must report when sample (e, xv) arrives
    function automatic obs_t model_out(input int i, input logic e, input logic xv, input int r);
        obs_t o;
        int   sat;
        o   = '0;
        sat = (1 << CW[i]) - 1;
        if (e && (xv != 1'(POLA[i])) && r > 0) begin
            o.y   = (r >= MINR[i]) && (MAXR[i] == 0 || (r <= MAXR[i] && r < sat));
            o.len = o.y ? 8'((r < sat) ? r : sat) : 8'd0;
            o.ovf = o.y && (r >= sat);
        end
        return o;
    endfunction

    // Model: true (unbounded) length of the current run per instance
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                run[i]  <= 0;
                prev[i] <= '0;
            end else begin
                prev[i] <= model_out(i, en, x, run[i]);
                if (en) run[i] <= (x == 1'(POLA[i])) ? run[i] + 1 : 0;
            end
        end
    end

    task automatic chk(input string nm, input int idx, input obs_t act, input obs_t exp_o);
        n_cmp++;
        if (act !== exp_o) begin
            n_bad++;
            $display("FAIL %s u%0d t=%0t: got y=%b len=%0d ovf=%b, want y=%b len=%0d ovf=%b",
                     nm, idx, $time, act.y, act.len, act.ovf, exp_o.y, exp_o.len, exp_o.ovf);
        end
    endtask

    task automatic lit(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // Per-cycle comparison against the model, plus pulse logging
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            obs_t act;
            obs_t expv;
            act.y   = y_a[i];
            act.ovf = ovf_a[i];
            act.len = len_a[i];
            expv    = REG_OUT ? prev[i] : model_out(i, en, x, run[i]);
            chk("cycle", i, act, expv);
            if (y_a[i] === 1'b1) begin
                pcnt[i]     <= pcnt[i] + 1;
                last_len[i] <= int'(len_a[i]);
                last_ovf[i] <= int'(ovf_a[i]);
            end
        end
    end

    task automatic step(input logic e, input logic xv);
        @(posedge clk);
        #1;
        en = e;
        x  = xv;
        @(negedge clk);
    endtask

    task automatic ones(input int n);
        repeat (n) step(1'b1, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    task automatic mark();
        for (int i = 0; i < NI; i++) base[i] = pcnt[i];
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        en    = 1'b1;
        x     = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        en    = 1'b0;
        x     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            pcnt[i]     = 0;
            last_len[i] = 0;
            last_ovf[i] = 0;
        end
        rst_n = 1'b0;
        en    = 1'b1;
        x     = 1'b1;
        repeat (3) @(negedge clk);
        lit("reset_y", int'(y_a[0]), 0);
        lit("reset_len", int'(len_a[0]), 0);
        #2;
        rst_n = 1'b1;
        en    = 1'b0;

        // Basic run of three ones
        mark();
        step(1, 0); ones(3); step(1, 0); idle();
        lit("t1_pulses", pcnt[0] - base[0], 1);
        lit("t1_len", last_len[0], 3);
        lit("t1_ovf", last_ovf[0], 0);
        lit("t1_cntw1_len", last_len[5], 1);
        lit("t1_cntw1_ovf", last_ovf[5], 1);

        // MIN_RUN=3: short run rejected, run of three accepted
        mark();
        ones(2); step(1, 0); idle();
        lit("t2_min_short", pcnt[1] - base[1], 0);
        lit("t2_dflt_len", last_len[0], 2);
        mark();
        ones(3); step(1, 0); idle();
        lit("t2_min_ok", pcnt[1] - base[1], 1);
        lit("t2_min_len", last_len[1], 3);

        // MAX_RUN=4 bound
        mark();
        ones(4); step(1, 0); idle();
        lit("t3_max_ok", pcnt[2] - base[2], 1);
        lit("t3_max_len", last_len[2], 4);
        mark();
        ones(5); step(1, 0); idle();
        lit("t3_max_over", pcnt[2] - base[2], 0);

        // 3-bit counter saturation and MAX_RUN at saturation value
        mark();
        ones(9); step(1, 0); idle();
        lit("t4_sat_len", last_len[3], 7);
        lit("t4_sat_ovf", last_ovf[3], 1);
        lit("t4_max7_sat", pcnt[6] - base[6], 0);
        mark();
        ones(6); step(1, 0); idle();
        lit("t4_max7_len", last_len[6], 6);
        lit("t4_max7_ovf", last_ovf[6], 0);
        mark();
        ones(7); step(1, 0); idle();
        lit("t4_exact7_ovf", last_ovf[3], 1);
        lit("t4_exact7_max", pcnt[6] - base[6], 0);

        // Enable gap inside a run, then reset aborting a run
        mark();
        step(1, 1); step(0, 0); step(1, 1); step(1, 0); idle();
        lit("t5_gap_len", last_len[0], 2);
        lit("t5_gap_pulses", pcnt[0] - base[0], 1);
        mark();
        ones(2); rst_pulse(); step(1, 0); idle();
        lit("t5_rst_nopulse", pcnt[0] - base[0], 0);

        // POL=0 instance
        step(1, 1); idle();
        mark();
        step(1, 1); step(1, 0); step(1, 0); step(1, 1); idle();
        lit("t6_pol0_pulses", pcnt[4] - base[4], 1);
        lit("t6_pol0_len", last_len[4], 2);

        // Back-to-back runs separated by a single non-POL sample
        mark();
        ones(2); step(1, 0); step(1, 1); step(1, 0); idle();
        lit("t7_b2b_pulses", pcnt[0] - base[0], 2);
        lit("t7_b2b_len", last_len[0], 1);

        // Full 8-bit saturation
        mark();
        ones(300); step(1, 0); idle();
        lit("t8_sat255_len", last_len[0], 255);
        lit("t8_sat255_ovf", last_ovf[0], 1);
        lit("t8_max4_long", pcnt[2] - base[2], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
